// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seven-segment scanner: active-low segment patterns,
// the anode-off code and the per-frame shadow register layout.
package seg7_scan_pkg;

    // Segment bit 0 = a ... bit 6 = g, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef struct packed {
        logic [3:0][3:0] digit;       // digit[3] = thosent ... digit[0] = ones
        logic            blank_lz;
        logic [3:0]      blink_mask;
        logic [3:0]      dp_mask;
    } shadow_t;

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment pattern; codes 10-15 render as a dash.
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame shadow capture,
// leading-zero blanking, per-digit blink and decimal points. All pins registered.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYC    = 250,
    parameter int BLINK_FRAMES = 100
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] thosent,
    input  logic [3:0] hundred,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] slot_cnt, slot_cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    shadow_t       shadow, shadow_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_phase, blink_phase_nxt;
    logic          capture;

    logic [3:0]    digit_code;
    logic [6:0]    pattern;
    logic [3:0]    digit_zero;
    logic [3:0]    zero_from;
    logic          suppress;
    logic [3:0]    an_nxt;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        slot_cnt_nxt    = slot_cnt + CW'(1);
        idx_nxt         = idx;
        capture         = 1'b0;
        shadow_nxt      = shadow;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;

        if (slot_cnt == SLOT_LAST) begin
            slot_cnt_nxt = '0;
            idx_nxt      = idx - 2'd1;
            capture      = (idx == 2'd0);
        end

        if (capture) begin
            shadow_nxt.digit      = {thosent, hundred, tens, ones};
            shadow_nxt.blank_lz   = blank_lz;
            shadow_nxt.blink_mask = blink_mask;
            shadow_nxt.dp_mask    = dp_mask;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt   = blink_cnt + BW'(1);
            end
        end
    end

    // Output registers are loaded from next-state values so the pins line up
    // with the slot counter and pick up freshly captured shadows immediately.
    assign digit_code = shadow_nxt.digit[idx_nxt];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_zero[i] = (shadow_nxt.digit[i] == 4'd0);
        end
    end

    assign zero_from = {digit_zero[3],
                        &digit_zero[3:2],
                        &digit_zero[3:1],
                        &digit_zero[3:0]};

    assign suppress = (shadow_nxt.blank_lz && (idx_nxt != 2'd0) && zero_from[idx_nxt])
                   || (shadow_nxt.blink_mask[idx_nxt] && !blink_phase_nxt);

    assign an_nxt = ((slot_cnt_nxt >= BLANK_END) && !suppress) ? an_select(idx_nxt) : AN_OFF;

    seg7_decode u_decode (
        .code    (digit_code),
        .pattern (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            idx         <= 2'd3;
            shadow      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            slot_cnt    <= slot_cnt_nxt;
            idx         <= idx_nxt;
            shadow      <= shadow_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            an          <= an_nxt;
            // Shadow and index only move at slot boundaries, so seg/dp settle there.
            seg         <= pattern;
            dp          <= ~shadow_nxt.dp_mask[idx_nxt];
            frame_tick  <= capture;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: a frame/slot arithmetic model checked every cycle,
// plus hand-computed directed expectations.
module tb_seg7_scan;

    localparam int R  = 8;
    localparam int B  = 2;
    localparam int BF = 2;
    localparam int FR = 4 * R;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] thosent = 4'd0, hundred = 4'd0, tens = 4'd0, ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic [3:0] blink_mask = 4'd0, dp_mask = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit running = 1'b0;

    // Model: cycles since reset release and the frame shadows.
    int         t = 0;
    logic [3:0] m_d [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic       m_lz = 1'b0;
    logic [3:0] m_blink = 4'd0, m_dp = 4'd0;

    seg7_scan #(
        .REFRESH_DIV  (R),
        .BLANK_CYC    (B),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .thosent    (thosent),
        .hundred    (hundred),
        .tens       (tens),
        .ones       (ones),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
            m_lz = 1'b0;
            m_blink = 4'd0;
            m_dp = 4'd0;
        end else begin
            t = t + 1;
            if (t % FR == 0) begin
                m_d[3] = thosent;
                m_d[2] = hundred;
                m_d[1] = tens;
                m_d[0] = ones;
                m_lz = blank_lz;
                m_blink = blink_mask;
                m_dp = dp_mask;
            end
        end
    end

    task automatic model_outputs(output logic [3:0] e_an, output logic [6:0] e_seg,
                                 output logic e_dp, output logic e_ft);
        int  pos, idx, k;
        bit  phase_on, all_zero, supp;
        if (!rst_n || t == 0) begin
            e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
        end else begin
            pos      = t % R;
            idx      = 3 - ((t / R) % 4);
            k        = t / FR;
            phase_on = ((k / BF) % 2) == 0;
            all_zero = 1'b1;
            for (int j = idx; j < 4; j++) if (m_d[j] != 4'd0) all_zero = 1'b0;
            supp  = (m_lz && idx > 0 && all_zero) || (m_blink[idx] && !phase_on);
            e_an  = (pos >= B && !supp) ? ~(4'b0001 << idx) : 4'b1111;
            e_seg = SEG_TAB[m_d[idx]];
            e_dp  = ~m_dp[idx];
            e_ft  = (t % FR) == 0;
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_ft;
        if (running) begin
            model_outputs(e_an, e_seg, e_dp, e_ft);
            n_tests++;
            if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft}) begin
                n_fail++;
                $display("FAIL model t=%0d: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                         t, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0d): got %0h, want %0h", name, t, got, exp);
        end
    endtask

    task automatic goto(input int target);
        repeat (target - t) @(negedge clk);
    endtask

    initial begin
        int found;
        int cnt [4];
        int lit;

        thosent = 4'd8; hundred = 4'd4; tens = 4'd0; ones = 4'd0;
        repeat (3) @(negedge clk);
        running = 1'b1;
        rst_n = 1'b1;

        // First frame_tick 32 cycles after release.
        found = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (frame_tick) begin found = i; break; end
        end
        check("first_tick_cycle", found, 32);

        // Normal scan of 8400.
        goto(36);  check("scan_d3_an", an, 4'b0111); check("scan_d3_seg", seg, 7'b0000000);
        goto(44);  check("scan_d2_an", an, 4'b1011); check("scan_d2_seg", seg, 7'b0011001);
        goto(52);  check("scan_d1_an", an, 4'b1101); check("scan_d1_seg", seg, 7'b1000000);
        goto(60);  check("scan_d0_an", an, 4'b1110); check("scan_d0_seg", seg, 7'b1000000);
        goto(64);
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        for (int j = 0; j < FR; j++) begin
            for (int d = 0; d < 4; d++) if (an[d] == 1'b0) cnt[d]++;
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) check($sformatf("lit_cycles_d%0d", d), cnt[d], 6);

        // Tear-free capture: change mid digit-2 slot of frame 3.
        goto(107); thosent = 4'd7;
        goto(128); check("tick_frame4", frame_tick, 1'b1);
        goto(132); check("tear_d3_seg", seg, 7'b1111000); check("tear_d3_an", an, 4'b0111);

        // Leading-zero blanking with 0400.
        goto(140); thosent = 4'd0; hundred = 4'd4; blank_lz = 1'b1;
        goto(160);
        lit = 0;
        for (int j = 0; j < R; j++) begin
            if (an != 4'b1111) lit++;
            @(negedge clk);
        end
        check("lz_d3_dark_cycles", lit, 0);
        goto(172); check("lz_d2_an", an, 4'b1011); check("lz_d2_seg", seg, 7'b0011001);
        goto(180); check("lz_d1_an", an, 4'b1101);
        goto(184); hundred = 4'd0;
        goto(196); check("lz0_d3_an", an, 4'b1111);
        goto(204); check("lz0_d2_an", an, 4'b1111);
        goto(212); check("lz0_d1_an", an, 4'b1111);
        goto(220); check("lz0_d0_an", an, 4'b1110); check("lz0_d0_seg", seg, 7'b1000000);

        // Blink on digit 0, decimal point on digit 2, value 1235.
        goto(222);
        thosent = 4'd1; hundred = 4'd2; tens = 4'd3; ones = 4'd5;
        blank_lz = 1'b0; blink_mask = 4'b0001; dp_mask = 4'b0100;
        goto(228); check("dp_d3", dp, 1'b1);
        goto(236); check("dp_d2", dp, 1'b0); check("d2_seg", seg, 7'b0100100);
        goto(252); check("blink_f7_dark", an, 4'b1111);
        goto(284); check("blink_f8_lit", an, 4'b1110); check("blink_f8_seg", seg, 7'b0010010);
        goto(316); check("blink_f9_lit", an, 4'b1110);
        goto(348); check("blink_f10_dark", an, 4'b1111);
        goto(360); tens = 4'hA; blink_mask = 4'b0000;
        goto(380); check("blink_f11_dark", an, 4'b1111);

        // Invalid code on tens.
        goto(404); check("dash_d1_an", an, 4'b1101); check("dash_d1_seg", seg, 7'b0111111);

        // Asynchronous reset mid-slot while digit 0 is lit.
        goto(410); check("pre_reset_an", an, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'b1111);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dp", dp, 1'b1);
        check("async_rst_tick", frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        goto(4);  check("post_rst_d3_an", an, 4'b0111); check("post_rst_d3_seg", seg, 7'b1000000);
        goto(32); check("post_rst_tick", frame_tick, 1'b1);
        goto(44);

        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
